// File: rtl/sevseg_pkg.sv
// Segment patterns shared by the seven-segment scan driver.
// Bit order is abcdefg, a = MSB, 1 = lit.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Hex letters are only shown when hex mode is on.
  function automatic logic [6:0] hex_or_blank(
    input logic       hex_mode,
    input logic [6:0] pat
  );
    return hex_mode ? pat : SEG_BLANK;
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Nibble to seven-segment decoder, purely combinational.
// Codes 10-15 are letters in hex mode, blank otherwise.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  // Full 16-entry lookup; every code is covered.
  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = hex_or_blank(i_hex_mode, SEG_A);
      4'hB: o_seg = hex_or_blank(i_hex_mode, SEG_B);
      4'hC: o_seg = hex_or_blank(i_hex_mode, SEG_C);
      4'hD: o_seg = hex_or_blank(i_hex_mode, SEG_D);
      4'hE: o_seg = hex_or_blank(i_hex_mode, SEG_E);
      4'hF: o_seg = hex_or_blank(i_hex_mode, SEG_F);
    endcase
  end

endmodule

// File: rtl/sevseg_mux_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous update.
// Define SEVSEG_LZB_EN to blank leading zero digits.
module sevseg_mux_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ack,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_pend_data;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_valid;
  logic [DW-1:0]         r_disp_data;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_load_ack;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_hex_mode;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [6:0]            w_dec_seg;
  logic [6:0]            w_seg_out;

  assign w_tick     = (r_presc == PRE_LAST);
  assign w_wrap     = w_tick && (r_idx == IDX_LAST);
  assign w_hex_mode = (HEX_MODE != 0);

  // Prescaler: one tick every REFRESH_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Digit index advances on each tick and wraps at the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      if (r_idx == IDX_LAST) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Pending buffer and display register; display only changes on wrap.
  // A load landing exactly on the wrap goes straight to the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
    end else if (w_wrap) begin
      if (load) begin
        r_disp_data  <= data_in;
        r_disp_dp    <= dp_in;
        r_pend_valid <= 1'b0;
      end else if (r_pend_valid) begin
        r_disp_data  <= r_pend_data;
        r_disp_dp    <= r_pend_dp;
        r_pend_valid <= 1'b0;
      end
    end else if (load) begin
      r_pend_data  <= data_in;
      r_pend_dp    <= dp_in;
      r_pend_valid <= 1'b1;
    end
  end

  // Select the active digit's nibble, point and anode.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_an_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp_data[4*i +: 4];
        w_dp_sel    = r_disp_dp[i];
        w_an_sel[i] = 1'b1;
      end
    end
  end

  sevseg_decode u_decode (
    .i_nibble   (w_nib),
    .i_hex_mode (w_hex_mode),
    .o_seg      (w_dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] w_blank;

  // Mark digits that are zero and have only zeros above them.
  always_comb begin : lzb
    logic v_run;
    v_run   = 1'b1;
    w_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      v_run      = v_run & (r_disp_data[4*i +: 4] == 4'h0);
      w_blank[i] = v_run;
    end
  end

  assign w_seg_out = (|(w_blank & w_an_sel)) ? SEG_BLANK : w_dec_seg;
`else
  assign w_seg_out = w_dec_seg;
`endif

  // Registered digit outputs plus the frame and ack pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b0;
      r_an         <= '0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_out;
      r_dp         <= w_dp_sel;
      r_an         <= w_an_sel;
      r_load_ack   <= w_wrap && (load || r_pend_valid);
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign load_ack   = r_load_ack;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sevseg_mux_driver.sv
// Randomised bench for sevseg_mux_driver, hex and decimal builds.
// Reference model works from elapsed cycles since reset release.
module tb_sevseg_mux_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * R;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;

  logic       h_ack, h_dp, h_fd;
  logic [6:0] h_seg;
  logic [3:0] h_an;
  logic       d_ack, d_dp, d_fd;
  logic [6:0] d_seg;
  logic [3:0] d_an;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dpd, m_pdp;
  logic        m_pv;
  logic [6:0]  pat [16];

  always #5 clk = ~clk;

  sevseg_mux_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .HEX_MODE   (1)
  ) u_dut_h (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load_ack   (h_ack),
    .seg        (h_seg),
    .dp         (h_dp),
    .an         (h_an),
    .frame_done (h_fd)
  );

  sevseg_mux_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .HEX_MODE   (0)
  ) u_dut_d (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .load_ack   (d_ack),
    .seg        (d_seg),
    .dp         (d_dp),
    .an         (d_an),
    .frame_done (d_fd)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, n);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int dig, input bit hex);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = m_disp >> (4 * dig);
    nib   = upper[3:0];
`ifdef SEVSEG_LZB_EN
    if (dig != 0 && upper == 16'h0) return 7'b0;
`endif
    if (nib > 4'd9 && !hex) return 7'b0;
    return pat[nib];
  endfunction

  task automatic model_reset();
    n      = 0;
    m_disp = '0;
    m_dpd  = '0;
    m_pend = '0;
    m_pdp  = '0;
    m_pv   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_seg_h"}, 32'(h_seg), 32'd0);
    chk({tag, "_an_h"},  32'(h_an),  32'd0);
    chk({tag, "_dp_h"},  32'(h_dp),  32'd0);
    chk({tag, "_ack_h"}, 32'(h_ack), 32'd0);
    chk({tag, "_fd_h"},  32'(h_fd),  32'd0);
    chk({tag, "_seg_d"}, 32'(d_seg), 32'd0);
    chk({tag, "_an_d"},  32'(d_an),  32'd0);
  endtask

  // One clock: apply inputs, advance the model, compare both builds.
  task automatic step(input logic ld, input logic [15:0] d,
                      input logic [3:0] p);
    int         dig;
    logic [6:0] eh, ed;
    logic       edp, wrap, eack;
    logic [3:0] ean;
    load    = ld;
    data_in = d;
    dp_in   = p;
    @(posedge clk);
    #1;
    n++;
    dig  = ((n - 1) / R) % N;
    eh   = exp_seg(dig, 1'b1);
    ed   = exp_seg(dig, 1'b0);
    edp  = m_dpd[dig];
    ean  = 4'(1 << dig);
    wrap = (n % F) == 0;
    eack = wrap && (ld || m_pv);
    if (wrap) begin
      if (ld) begin
        m_disp = d;
        m_dpd  = p;
        m_pv   = 1'b0;
      end else if (m_pv) begin
        m_disp = m_pend;
        m_dpd  = m_pdp;
        m_pv   = 1'b0;
      end
    end else if (ld) begin
      m_pend = d;
      m_pdp  = p;
      m_pv   = 1'b1;
    end
    chk("seg_hex", 32'(h_seg), 32'(eh));
    chk("seg_dec", 32'(d_seg), 32'(ed));
    chk("an_hex",  32'(h_an),  32'(ean));
    chk("an_dec",  32'(d_an),  32'(ean));
    chk("dp_hex",  32'(h_dp),  32'(edp));
    chk("dp_dec",  32'(d_dp),  32'(edp));
    chk("ack_hex", 32'(h_ack), 32'(eack));
    chk("ack_dec", 32'(d_ack), 32'(eack));
    chk("fd_hex",  32'(h_fd),  32'(wrap));
    chk("fd_dec",  32'(d_fd),  32'(wrap));
    load = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (n < target) step(1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    int          k;
    logic        ld;
    logic [15:0] d;
    pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    model_reset();

    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero("rst_init");
    end
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 16'h1234, 4'b0001);
    idle_until(F + 8);

    step(1'b1, 16'h1111, 4'b0010);
    idle_until(F + 12);
    step(1'b1, 16'h2222, 4'b0100);
    idle_until(3 * F);

    idle_until(4 * F - 1);
    step(1'b1, 16'h5678, 4'b1010);
    idle_until(6 * F);

    idle_until(6 * F + 3);
    step(1'b1, 16'hFCBA, 4'b0000);
    idle_until(8 * F + 2);
    step(1'b1, 16'hD0EA, 4'b1111);
    idle_until(10 * F);

    repeat (1200) begin
      ld = ($urandom_range(0, 11) == 0);
      k  = $urandom_range(0, 4);
      d  = 16'($urandom) >> (4 * k);
      step(ld, d, 4'($urandom));
    end

    idle_until(((n / F) + 1) * F + 2);
    step(1'b1, 16'h0050, 4'b0100);
    idle_until(n + 3 * F);

    step(1'b1, 16'h9999, 4'hF);
    idle_until(n + 5);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_until(5 * F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
